// File: rtl/mux8_1_reg.sv
// Registered 8:1 bit selector, WIDTH independent lanes sharing one select.
// Define MUX8_1_REG_PARITY_EN to add a registered per-lane parity output (out_par).

module mux8_1_reg_mux4 (
   input  logic [3:0] d,
   input  logic [1:0] s,
   output logic       y
);
   // Ternary tree keeps X on unselected inputs from reaching y
   assign y = s[1] ? (s[0] ? d[3] : d[2]) : (s[0] ? d[1] : d[0]);
endmodule

module mux8_1_reg_mux2 (
   input  logic a0,
   input  logic a1,
   input  logic s,
   output logic y
);
   assign y = s ? a1 : a0;
endmodule

module mux8_1_reg #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [8*WIDTH-1:0] in,
   input  logic [2:0]         sel,
   input  logic               en,
   output logic [WIDTH-1:0]   out,
`ifdef MUX8_1_REG_PARITY_EN
   output logic [WIDTH-1:0]   out_par,
`endif
   output logic               out_valid
);

   logic [WIDTH-1:0] lo_sel;
   logic [WIDTH-1:0] hi_sel;
   logic [WIDTH-1:0] y_sel;
   logic [WIDTH-1:0] out_d, out_q;
   logic             valid_d, valid_q;

   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      mux8_1_reg_mux4 u_lo (
         .d (in[8*k +: 4]),
         .s (sel[1:0]),
         .y (lo_sel[k])
      );
      mux8_1_reg_mux4 u_hi (
         .d (in[8*k+4 +: 4]),
         .s (sel[1:0]),
         .y (hi_sel[k])
      );
      mux8_1_reg_mux2 u_fin (
         .a0 (lo_sel[k]),
         .a1 (hi_sel[k]),
         .s  (sel[2]),
         .y  (y_sel[k])
      );
   end

   always_comb begin
      out_d   = en ? y_sel : out_q;
      valid_d = en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

`ifdef MUX8_1_REG_PARITY_EN
   logic [WIDTH-1:0] lane_par;
   logic [WIDTH-1:0] par_d, par_q;

   for (genvar k = 0; k < WIDTH; k++) begin : g_par
      assign lane_par[k] = ^in[8*k +: 8];
   end

   always_comb begin
      par_d = en ? lane_par : par_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= '0;
      else       par_q <= par_d;
   end

   assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux8_1_reg.sv
// Self-checking bench for mux8_1_reg: a WIDTH=1 and a WIDTH=4 instance driven in lockstep,
// with expected results queued at drive time and compared one cycle later.

module tb_mux8_1_reg;

   logic        clk;
   logic        reset;
   logic [7:0]  in1;
   logic [31:0] in4;
   logic [2:0]  sel;
   logic        en;
   logic [0:0]  out1;
   logic [3:0]  out4;
   logic        valid1, valid4;
`ifdef MUX8_1_REG_PARITY_EN
   logic [0:0]  par1;
   logic [3:0]  par4;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       out1;
      logic [3:0] out4;
      logic       valid;
      logic       par1;
      logic [3:0] par4;
   } exp_t;

   exp_t exp_q[$];

   logic       model_out1;
   logic [3:0] model_out4;
   logic       model_valid;
   logic       model_par1;
   logic [3:0] model_par4;

   mux8_1_reg #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in        (in1),
      .sel       (sel),
      .en        (en),
      .out       (out1),
`ifdef MUX8_1_REG_PARITY_EN
      .out_par   (par1),
`endif
      .out_valid (valid1)
   );

   mux8_1_reg #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .in        (in4),
      .sel       (sel),
      .en        (en),
      .out       (out4),
`ifdef MUX8_1_REG_PARITY_EN
      .out_par   (par4),
`endif
      .out_valid (valid4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic resetModel();
      model_out1  = 1'b0;
      model_out4  = '0;
      model_valid = 1'b0;
      model_par1  = 1'b0;
      model_par4  = '0;
   endtask

   // Pops the oldest expectation and compares it with what both instances now show
   task automatic collectResult(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      checkOutput({tag, "_out1"}, {31'd0, out1}, {31'd0, e.out1});
      checkOutput({tag, "_out4"}, {28'd0, out4}, {28'd0, e.out4});
      checkOutput({tag, "_valid1"}, {31'd0, valid1}, {31'd0, e.valid});
      checkOutput({tag, "_valid4"}, {31'd0, valid4}, {31'd0, e.valid});
`ifdef MUX8_1_REG_PARITY_EN
      checkOutput({tag, "_par1"}, {31'd0, par1}, {31'd0, e.par1});
      checkOutput({tag, "_par4"}, {28'd0, par4}, {28'd0, e.par4});
`endif
   endtask

   // Drives one cycle of stimulus, predicts the registered result, then checks it after the edge
   task automatic applyStimulus(input string tag, input logic [7:0] a1, input logic [31:0] a4,
                                input logic [2:0] s, input logic e_n);
      exp_t e;
      logic [7:0] lane;
      in1 = a1;
      in4 = a4;
      sel = s;
      en  = e_n;
      if (e_n) begin
         model_out1 = a1[s];
         model_par1 = ^a1;
         for (int k = 0; k < 4; k++) begin
            lane = a4[8*k +: 8];
            model_out4[k] = lane[s];
            model_par4[k] = ^lane;
         end
      end
      model_valid = e_n;
      e.out1  = model_out1;
      e.out4  = model_out4;
      e.valid = model_valid;
      e.par1  = model_par1;
      e.par4  = model_par4;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      collectResult(tag);
   endtask

   initial begin
      reset = 1'b1;
      in1   = '0;
      in4   = '0;
      sel   = '0;
      en    = 1'b0;
      resetModel();
      #12;
      checkOutput("reset_out1", {31'd0, out1}, 32'd0);
      checkOutput("reset_out4", {28'd0, out4}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid1}, 32'd0);
      reset = 1'b0;

      $display("[TB] exhaustive select sweep");
      for (int s = 0; s < 8; s++) begin
         for (int v = 0; v < 256; v++) begin
            applyStimulus("sweep", v[7:0], $urandom, s[2:0], 1'b1);
         end
      end

      applyStimulus("a5_sel2", 8'hA5, 32'h0, 3'd2, 1'b1);
      applyStimulus("a5_sel1", 8'hA5, 32'h0, 3'd1, 1'b1);

      $display("[TB] asynchronous reset");
      applyStimulus("rst_load", 8'hFF, 32'hFFFF_FFFF, 3'd7, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      resetModel();
      checkOutput("rst_async_out1", {31'd0, out1}, 32'd0);
      checkOutput("rst_async_out4", {28'd0, out4}, 32'd0);
      checkOutput("rst_async_valid", {31'd0, valid1}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst_hold_out1", {31'd0, out1}, 32'd0);
      checkOutput("rst_hold_valid", {31'd0, valid4}, 32'd0);
      reset = 1'b0;
      applyStimulus("rst_rel_idle", 8'hFF, 32'hFFFF_FFFF, 3'd7, 1'b0);
      applyStimulus("rst_rel_cap", 8'hFF, 32'hFFFF_FFFF, 3'd7, 1'b1);

      $display("[TB] enable hold");
      applyStimulus("hold_cap", 8'h01, 32'h0101_0101, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("hold_idle", 8'h00, 32'h0, 3'd0, 1'b0);
      end

      $display("[TB] multi-lane");
      applyStimulus("lanes_sel0", 8'h01, 32'h8040_0201, 3'd0, 1'b1);
      applyStimulus("lanes_sel7", 8'h80, 32'h8040_0201, 3'd7, 1'b1);
      checkOutput("lanes_direct", {28'd0, out4}, 32'h8);

      $display("[TB] X isolation");
      applyStimulus("xiso", 8'bxxxx_xxx1, 32'hxxxx_xxx1, 3'd0, 1'b1);
      applyStimulus("xiso_hi", 8'b1xxx_xxxx, 32'h8xxx_xxxx, 3'd7, 1'b1);

      $display("[TB] parity patterns");
      applyStimulus("par_07", 8'h07, 32'h0F07_0F07, 3'd0, 1'b1);
      applyStimulus("par_0f", 8'h0F, 32'h070F_070F, 3'd3, 1'b1);
      applyStimulus("par_hold", 8'h01, 32'h0101_0101, 3'd3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
